nios_imageline_mm_slave_gen: RTL and testbench

//  Parametrised Avalon-MM slave between the Nios and the imageline/filter datapath.

---
 rtl/nios_imageline_mm_slave_gen_if.sv | 24 ++
 rtl/nios_imageline_mm_slave_gen.sv | 185 ++++++++++++++++++
 tb/tb_nios_imageline_mm_slave_gen.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_imageline_mm_slave_gen_if.sv
// Avalon-MM bus bundle between the Nios fabric and the imageline slave.
// The master drives the request; the slave answers with readdata and waitrequest.
interface nios_imageline_mm_slave_gen_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11
);
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              waitrequest;

   modport master (
      output address, chipselect, read, write, writedata,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, chipselect, read, write, writedata,
      output readdata, waitrequest
   );
endinterface

// File: rtl/nios_imageline_mm_slave_gen.sv
// Avalon-MM register slave for the imageline/filter datapath: coefficient and
// control registers, a posted-write FIFO toward SDRAM and latency-counted SDRAM reads.
module nios_imageline_mm_slave_gen #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 11,
   parameter int NUM_COEF    = 9,
   parameter int COEF_W      = 8,
   parameter int SCALE_W     = 4,
   parameter int RD_LATENCY  = 2,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic                       Clock,
   input  logic                       Reset,
   nios_imageline_mm_slave_gen_if.slave bus,
   output logic [DATA_W-1:0]          Filter_config,
   output logic [NUM_COEF*COEF_W-1:0] coef_bus,
   output logic [SCALE_W-1:0]         scale_factor,
   output logic [2:0]                 State_reload,
   input  logic [2:0]                 State_read,
   output logic                       SDRAM_wr_src,
   output logic                       SDRAM_rd_src,
   output logic                       SDRAM_wren,
   output logic [DATA_W-1:0]          SDRAM_wr_data,
   input  logic                       SDRAM_wr_ready,
   output logic                       SDRAM_rden,
   input  logic [DATA_W-1:0]          SDRAM_rd_data,
   output logic [1:0]                 dbg_state
);

   localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      WR_STALL = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t             state;
   logic [DATA_W-1:0]  readdata_q;
   logic [DATA_W-1:0]  stall_data;
   logic [3:0]         lat_cnt;

   logic [DATA_W-1:0]  fifo_mem [WFIFO_DEPTH];
   logic [PTR_W-1:0]   wptr;
   logic [PTR_W-1:0]   rptr;
   logic [CNT_W-1:0]   count;

   logic               req;
   logic               fifo_empty;
   logic               pop;
   logic               can_accept;
   logic               idle_wr0;
   logic               push;
   logic [DATA_W-1:0]  push_data;
   logic [DATA_W-1:0]  rd_mux;
   logic [16:0]        status;

   // Valid/ready contract: a request is chipselect & (read|write); it is held until
   // the single cycle where waitrequest is low (the RESP state), then it completes.
   always_comb begin
      req        = bus.chipselect & (bus.read | bus.write);
      fifo_empty = (count == '0);
      pop        = !Reset & !fifo_empty & SDRAM_wr_ready;
      can_accept = (count < CNT_W'(WFIFO_DEPTH)) | pop;
      idle_wr0   = (state == IDLE) & req & bus.write & (bus.address == '0);
      push       = !Reset & can_accept & (idle_wr0 | (state == WR_STALL));
      push_data  = (state == WR_STALL) ? stall_data : bus.writedata;
   end

   assign bus.waitrequest = req & (Reset | (state != RESP));
   assign bus.readdata    = readdata_q;
   assign SDRAM_wren      = pop;
   assign SDRAM_wr_data   = fifo_empty ? '0 : fifo_mem[rptr];
   assign SDRAM_rden      = !Reset & (state == IDLE) & req & bus.read & !bus.write
                            & (bus.address == '0);
   assign dbg_state       = state;

   always_comb begin
      status = {fifo_empty, 8'(count), 3'b000, State_read, SDRAM_wr_src, SDRAM_rd_src};
      rd_mux = '0;
      if (bus.address == ADDR_W'(1)) begin
         rd_mux = DATA_W'(status);
      end else if (bus.address == ADDR_W'(4)) begin
         rd_mux = Filter_config;
      end else if (bus.address == ADDR_W'(8)) begin
         rd_mux = DATA_W'(scale_factor);
      end else begin
         for (int i = 0; i < NUM_COEF; i++) begin
            if (bus.address == ADDR_W'(16 + i)) begin
               rd_mux = DATA_W'(coef_bus[i*COEF_W +: COEF_W]);
            end
         end
      end
   end

   // Storage is left unreset; the empty flag masks stale contents on the head port.
   always_ff @(posedge Clock) begin
      if (push) begin
         fifo_mem[wptr] <= push_data;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state         <= IDLE;
         readdata_q    <= '0;
         stall_data    <= '0;
         lat_cnt       <= '0;
         Filter_config <= '0;
         coef_bus      <= '0;
         scale_factor  <= '0;
         State_reload  <= '0;
         SDRAM_wr_src  <= 1'b0;
         SDRAM_rd_src  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (bus.write) begin
                     if (bus.address == '0) begin
                        stall_data <= bus.writedata;
                        state      <= push ? RESP : WR_STALL;
                     end else begin
                        if (bus.address == ADDR_W'(1)) begin
                           State_reload <= bus.writedata[4:2];
                           SDRAM_wr_src <= bus.writedata[1];
                           SDRAM_rd_src <= bus.writedata[0];
                        end
                        if (bus.address == ADDR_W'(4)) Filter_config <= bus.writedata;
                        if (bus.address == ADDR_W'(8)) scale_factor <= bus.writedata[SCALE_W-1:0];
                        for (int i = 0; i < NUM_COEF; i++) begin
                           if (bus.address == ADDR_W'(16 + i)) begin
                              coef_bus[i*COEF_W +: COEF_W] <= bus.writedata[COEF_W-1:0];
                           end
                        end
                        state <= RESP;
                     end
                  end else if (bus.address == '0) begin
                     // rden pulses this cycle; lat_cnt numbers the cycles after it.
                     lat_cnt <= 4'd1;
                     state   <= RD_WAIT;
                  end else begin
                     readdata_q <= rd_mux;
                     state      <= RESP;
                  end
               end
            end
            RD_WAIT: begin
               if (lat_cnt == 4'(RD_LATENCY)) begin
                  readdata_q <= SDRAM_rd_data;
                  state      <= RESP;
               end else begin
                  lat_cnt <= lat_cnt + 4'd1;
               end
            end
            WR_STALL: begin
               if (push) state <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nios_imageline_mm_slave_gen.sv
// Bench for nios_imageline_mm_slave_gen: directed steps plus random register traffic
// checked against a register/queue model of the slave.
module tb_nios_imageline_mm_slave_gen;
   localparam int DW = 32, AW = 11, NC = 9, CW = 8, SW = 4, LAT = 2, DEPTH = 4;
   localparam logic [1:0] ST_IDLE = 2'd0, ST_WR_STALL = 2'd2;

   logic              Clock = 1'b0;
   logic              Reset;
   logic [DW-1:0]     Filter_config;
   logic [NC*CW-1:0]  coef_bus;
   logic [SW-1:0]     scale_factor;
   logic [2:0]        State_reload;
   logic [2:0]        State_read;
   logic              SDRAM_wr_src, SDRAM_rd_src;
   logic              SDRAM_wren;
   logic [DW-1:0]     SDRAM_wr_data;
   logic              SDRAM_wr_ready;
   logic              SDRAM_rden;
   logic [DW-1:0]     SDRAM_rd_data;
   logic [1:0]        dbg_state;

   nios_imageline_mm_slave_gen_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   nios_imageline_mm_slave_gen #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_COEF(NC), .COEF_W(CW), .SCALE_W(SW),
      .RD_LATENCY(LAT), .WFIFO_DEPTH(DEPTH)
   ) dut (
      .Clock(Clock), .Reset(Reset), .bus(bus),
      .Filter_config(Filter_config), .coef_bus(coef_bus), .scale_factor(scale_factor),
      .State_reload(State_reload), .State_read(State_read),
      .SDRAM_wr_src(SDRAM_wr_src), .SDRAM_rd_src(SDRAM_rd_src),
      .SDRAM_wren(SDRAM_wren), .SDRAM_wr_data(SDRAM_wr_data), .SDRAM_wr_ready(SDRAM_wr_ready),
      .SDRAM_rden(SDRAM_rden), .SDRAM_rd_data(SDRAM_rd_data), .dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 Clock = ~Clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- counters and reference model ----------------
   int n_cmp = 0, n_mis = 0;
   int rden_seen = 0, wren_seen = 0;
   logic [DW-1:0] exp_q[$];

   logic [DW-1:0] m_filt;
   logic [SW-1:0] m_scale;
   logic [CW-1:0] m_coef [NC];
   logic [2:0]    m_reload;
   logic          m_wsrc, m_rsrc;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_filt = '0; m_scale = '0; m_reload = '0; m_wsrc = 1'b0; m_rsrc = 1'b0;
      for (int i = 0; i < NC; i++) m_coef[i] = '0;
      exp_q.delete();
   endfunction

   function automatic void model_write(input int a, input logic [DW-1:0] d);
      if (a == 1) begin
         m_reload = d[4:2]; m_wsrc = d[1]; m_rsrc = d[0];
      end else if (a == 4) m_filt = d;
      else if (a == 8) m_scale = d[SW-1:0];
      else if (a >= 16 && a < 16 + NC) m_coef[a-16] = d[CW-1:0];
   endfunction

   function automatic logic [DW-1:0] model_read(input int a, input logic [2:0] sr);
      if (a == 1)
         return {15'b0, (exp_q.size() == 0), 8'(exp_q.size()), 3'b000, sr, m_wsrc, m_rsrc};
      if (a == 4) return m_filt;
      if (a == 8) return DW'(m_scale);
      if (a >= 16 && a < 16 + NC) return DW'(m_coef[a-16]);
      return '0;
   endfunction

   function automatic logic [NC*CW-1:0] model_coef_bus();
      logic [NC*CW-1:0] v;
      for (int i = 0; i < NC; i++) v[i*CW +: CW] = m_coef[i];
      return v;
   endfunction

   task automatic check_outputs(input string where);
      check({where, "_filter_config"}, Filter_config, m_filt);
      check({where, "_scale"}, scale_factor, m_scale);
      check({where, "_coef_bus"}, coef_bus, model_coef_bus());
      check({where, "_state_reload"}, State_reload, m_reload);
      check({where, "_wr_src"}, SDRAM_wr_src, m_wsrc);
      check({where, "_rd_src"}, SDRAM_rd_src, m_rsrc);
   endtask

   // ---------------- SDRAM side model and scoreboard ----------------
   logic [LAT-1:0] rd_pipe = '0;
   logic [DW-1:0]  rd_val  = '0;

   always @(posedge Clock) rd_pipe <= (rd_pipe << 1) | LAT'(SDRAM_rden);
   assign SDRAM_rd_data = rd_pipe[LAT-1] ? rd_val : ~rd_val;

   always @(negedge Clock) begin
      if (SDRAM_rden) rden_seen++;
      if (SDRAM_wren) begin
         wren_seen++;
         if (exp_q.size() == 0) check("wr_unexpected_pop", SDRAM_wren, 1'b0);
         else check("wr_data_order", SDRAM_wr_data, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks (entered just after a rising edge) ----------------
   task automatic avm_write(input int a, input logic [DW-1:0] d, output int cyc);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
      bus.address = AW'(a); bus.writedata = d;
      if (a == 0) exp_q.push_back(d);
      else model_write(a, d);
      cyc = 0;
      do begin
         @(negedge Clock);
         cyc++;
      end while (bus.waitrequest && cyc < 200);
      if (bus.waitrequest) check("write_timeout", bus.waitrequest, 1'b0);
      @(posedge Clock); #1;
      bus.chipselect = 1'b0; bus.write = 1'b0;
   endtask

   task automatic avm_read(input int a, output logic [DW-1:0] d, output int cyc);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0;
      bus.address = AW'(a);
      cyc = 0;
      do begin
         @(negedge Clock);
         cyc++;
      end while (bus.waitrequest && cyc < 200);
      if (bus.waitrequest) check("read_timeout", bus.waitrequest, 1'b0);
      d = bus.readdata;
      @(posedge Clock); #1;
      bus.chipselect = 1'b0; bus.read = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   int            cyc, cyc_a, w0, r0, a;
   logic [DW-1:0] d, d_a;
   int            addr_tab [12] = '{1, 2, 4, 8, 12, 16, 17, 20, 24, 25, 40, 2047};

   initial begin
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.address = '0; bus.writedata = '0;
      Reset = 1'b1; SDRAM_wr_ready = 1'b0; State_read = 3'd0;
      model_reset();

      // reset behaviour
      repeat (2) @(posedge Clock);
      #1 bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = AW'(4);
      @(negedge Clock);
      check("wait_during_reset", bus.waitrequest, 1'b1);
      @(posedge Clock); #1;
      bus.chipselect = 1'b0; bus.read = 1'b0; Reset = 1'b0;
      @(negedge Clock);
      check("rst_readdata", bus.readdata, 0);
      check("rst_waitrequest", bus.waitrequest, 1'b0);
      check("rst_wren", SDRAM_wren, 1'b0);
      check("rst_rden", SDRAM_rden, 1'b0);
      check("rst_wr_data", SDRAM_wr_data, 0);
      check("rst_state", dbg_state, ST_IDLE);
      check_outputs("rst");
      @(posedge Clock); #1;

      // control register
      avm_write(1, 32'h0000_0015, cyc);
      check("ctrl_wr_cycles", cyc, 2);
      check("ctrl_reload", State_reload, 3'd5);
      check("ctrl_wr_src", SDRAM_wr_src, 1'b0);
      check("ctrl_rd_src", SDRAM_rd_src, 1'b1);
      State_read = 3'd3;
      avm_read(1, d, cyc);
      check("ctrl_status", d, 32'h0001_000D);
      check("ctrl_rd_cycles", cyc, 2);

      // coefficients
      for (int i = 0; i < NC; i++) avm_write(16 + i, DW'(i + 1), cyc);
      check("coef_bus_ramp", coef_bus, 72'h09_08_07_06_05_04_03_02_01);
      avm_read(20, d, cyc);
      check("coef_rd_20", d, 32'h5);
      avm_read(40, d, cyc);
      check("unmapped_rd_40", d, 32'h0);

      // random register traffic
      SDRAM_wr_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         a = addr_tab[$urandom_range(0, 11)];
         State_read = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            avm_write(a, $urandom, cyc);
            check("rand_wr_cycles", cyc, 2);
            check_outputs("rand");
         end
         avm_read(a, d, cyc);
         check("rand_rd", d, model_read(a, State_read));
      end

      // posted writes with SDRAM not ready: four fit, the fifth stalls
      SDRAM_wr_ready = 1'b0;
      w0 = wren_seen;
      for (int i = 0; i < DEPTH; i++) begin
         avm_write(0, $urandom, cyc);
         check("fifo_push_cycles", cyc, 2);
      end
      avm_read(1, d, cyc);
      check("fifo_full_status", d, model_read(1, State_read));
      d_a = $urandom;
      fork
         avm_write(0, d_a, cyc_a);
         begin
            repeat (5) @(posedge Clock);
            #1;
            check("stall_state", dbg_state, ST_WR_STALL);
            check("no_pop_while_not_ready", wren_seen - w0, 0);
            SDRAM_wr_ready = 1'b1;
         end
      join
      check("stall_write_cycles", cyc_a, 7);
      repeat (8) @(posedge Clock);
      #1;
      check("drain_pop_count", wren_seen - w0, 5);
      avm_read(1, d, cyc);
      check("drained_status", d, model_read(1, State_read));
      check("drained_count_field", d[16:8], 9'h100);

      // SDRAM reads
      for (int k = 0; k < 3; k++) begin
         rd_val = (k == 0) ? 32'hCAFE_F00D : $urandom;
         r0 = rden_seen;
         avm_read(0, d, cyc);
         check("sdram_rd_data", d, rd_val);
         check("sdram_rd_cycles", cyc, LAT + 2);
         check("sdram_rden_pulses", rden_seen - r0, 1);
      end

      // full FIFO with ready: push and pop in the same cycle, no stall
      SDRAM_wr_ready = 1'b0;
      w0 = wren_seen;
      for (int i = 0; i < DEPTH; i++) avm_write(0, $urandom, cyc);
      fork
         avm_write(0, $urandom, cyc_a);
         begin
            SDRAM_wr_ready = 1'b1;
            @(posedge Clock); #1;
            SDRAM_wr_ready = 1'b0;
         end
      join
      check("full_push_pop_cycles", cyc_a, 2);
      avm_read(1, d, cyc);
      check("full_push_pop_status", d, model_read(1, State_read));
      check("full_push_pop_count", d[15:8], 8'd4);
      SDRAM_wr_ready = 1'b1;
      repeat (8) @(posedge Clock);
      #1;
      check("full_drain_pops", wren_seen - w0, 5);

      // reset while stalled on a full FIFO
      avm_write(4, 32'hA5A5_5A5A, cyc);
      SDRAM_wr_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) avm_write(0, $urandom, cyc);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = '0; bus.writedata = $urandom;
      @(posedge Clock); #1;
      @(negedge Clock);
      check("pre_reset_stall", dbg_state, ST_WR_STALL);
      @(posedge Clock); #1;
      Reset = 1'b1; bus.chipselect = 1'b0; bus.write = 1'b0;
      @(posedge Clock); #1;
      Reset = 1'b0; SDRAM_wr_ready = 1'b1;
      model_reset();
      @(negedge Clock);
      check("post_reset_state", dbg_state, ST_IDLE);
      check("post_reset_wren", SDRAM_wren, 1'b0);
      check("post_reset_readdata", bus.readdata, 0);
      check_outputs("post_reset");
      @(posedge Clock); #1;
      avm_read(1, d, cyc);
      check("post_reset_status", d, model_read(1, State_read));
      w0 = wren_seen;
      avm_write(0, 32'h1234_5678, cyc);
      repeat (4) @(posedge Clock);
      #1;
      check("post_reset_fifo_pop", wren_seen - w0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
